// File: rtl/hwjsoc_ocimem_access_arbiter.sv
// rtl/hwjsoc_ocimem_access_arbiter.sv - OCI RAM arbiter between the JTAG debug path and a system master
// Optional feature: define OCIMEM_ARB_ROUNDROBIN_EN for round-robin tie breaking;
// the default build uses fixed priority (JTAG wins ties).
module hwjsoc_ocimem_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_set_addr,
  input  logic              jtag_access,
  input  logic [37:0]       jdo,
  output logic [DATA_W-1:0] mon_dreg,
  output logic              mon_ready,
  output logic              jtag_overrun,
  input  logic              sys_req,
  input  logic              sys_we,
  input  logic [ADDR_W-1:0] sys_addr,
  input  logic [DATA_W-1:0] sys_wdata,
  output logic              sys_ack,
  output logic [DATA_W-1:0] sys_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                grant_jtag;
  logic                cur_we;
  logic                pending;
  logic                pend_we;
  logic [DATA_W-1:0]   pend_wdata;
  logic [ADDR_W-1:0]   jaddr;
  logic                jtag_busy;
  logic                jtag_win;
  logic                start;
  logic                unused_jdo;

  // jdo bits outside the field map are don't-care
  assign unused_jdo = ^{jdo[36], jdo[1:0]};

  // A JTAG command occupies the path from acceptance until its capture cycle ends
  assign jtag_busy = pending || (grant_jtag && (state != S_IDLE));
  assign start     = (state == S_IDLE) && (pending || sys_req);

`ifdef OCIMEM_ARB_ROUNDROBIN_EN
  logic last_grant_sys;

  // Tie goes to whoever was not served last
  assign jtag_win = pending && (!sys_req || last_grant_sys);

  // Remember the most recent grant for the next tie
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_sys <= 1'b1;
    end else if (start) begin
      last_grant_sys <= !jtag_win;
    end
  end
`else
  // Fixed priority: a pending JTAG command always wins
  assign jtag_win = pending;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: fixed IDLE -> ISSUE -> CAPTURE sequence per access
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (pending || sys_req) state_next = S_ISSUE;
      S_ISSUE:   state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // FSM outputs: memory strobes in ISSUE, system response in CAPTURE
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    sys_ack   = 1'b0;
    sys_rdata = '0;
    mon_ready = !jtag_busy;
    if (state == S_ISSUE) begin
      mem_en = 1'b1;
      mem_we = cur_we;
    end
    if ((state == S_CAPTURE) && !grant_jtag) begin
      sys_ack = 1'b1;
      if (!cur_we) sys_rdata = mem_rdata;
    end
  end

  // Grant latch, memory address/data hold, JTAG command and monitor registers
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_jtag   <= 1'b0;
      cur_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      pending      <= 1'b0;
      pend_we      <= 1'b0;
      pend_wdata   <= '0;
      jaddr        <= '0;
      mon_dreg     <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      if (start) begin
        grant_jtag <= jtag_win;
        cur_we     <= jtag_win ? pend_we : sys_we;
        mem_addr   <= jtag_win ? jaddr : sys_addr;
        mem_wdata  <= jtag_win ? pend_wdata : sys_wdata;
        if (jtag_win) jaddr <= jaddr + 1'b1;
      end
      if ((state == S_CAPTURE) && grant_jtag) begin
        mon_dreg <= cur_we ? mem_wdata : mem_rdata;
        pending  <= 1'b0;
      end
      // Strobes are only honoured when the 1-deep JTAG slot is free
      if (jtag_access || jtag_set_addr) begin
        if (jtag_busy) begin
          jtag_overrun <= 1'b1;
        end else if (jtag_access) begin
          pending    <= 1'b1;
          pend_we    <= jdo[35];
          pend_wdata <= jdo[34:3];
          if (jtag_set_addr) jtag_overrun <= 1'b1;
        end else begin
          jaddr <= jdo[ADDR_W+1:2];
          if (jdo[37]) jtag_overrun <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_hwjsoc_ocimem_access_arbiter.sv
// tb/tb_hwjsoc_ocimem_access_arbiter.sv - self-checking bench for hwjsoc_ocimem_access_arbiter
module tb_hwjsoc_ocimem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        jtag_set_addr = 1'b0;
  logic        jtag_access = 1'b0;
  logic [37:0] jdo = '0;
  logic [31:0] mon_dreg;
  logic        mon_ready;
  logic        jtag_overrun;
  logic        sys_req = 1'b0;
  logic        sys_we = 1'b0;
  logic [7:0]  sys_addr = '0;
  logic [31:0] sys_wdata = '0;
  logic        sys_ack;
  logic [31:0] sys_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;
  logic prev_ready = 1'b1;

  // memory environment and reference model state
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  ja = '0;
  logic [40:0] exp_mem_q [$];
  logic [31:0] exp_sys_q [$];
  logic [31:0] exp_mon_q [$];
  logic [2:0]  tie_j;

  hwjsoc_ocimem_access_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .jtag_set_addr(jtag_set_addr), .jtag_access(jtag_access), .jdo(jdo),
    .mon_dreg(mon_dreg), .mon_ready(mon_ready), .jtag_overrun(jtag_overrun),
    .sys_req(sys_req), .sys_we(sys_we), .sys_addr(sys_addr), .sys_wdata(sys_wdata),
    .sys_ack(sys_ack), .sys_rdata(sys_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // single-port RAM with one-cycle read latency
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // per-cycle comparison against the transaction-level model
  always @(negedge clk) begin
    if (started) begin
      if (mem_en === 1'b1) begin
        if (exp_mem_q.size() == 0) begin
          check("mem_unexpected_access", {63'd0, mem_en}, 64'd0);
        end else begin
          logic [40:0] e;
          e = exp_mem_q.pop_front();
          check("mem_we", {63'd0, mem_we}, {63'd0, e[40]});
          check("mem_addr", {56'd0, mem_addr}, {56'd0, e[39:32]});
          if (e[40]) check("mem_wdata", {32'd0, mem_wdata}, {32'd0, e[31:0]});
        end
      end else begin
        check("mem_we_idle", {63'd0, mem_we}, 64'd0);
      end
      if (sys_ack === 1'b1) begin
        if (exp_sys_q.size() == 0) begin
          check("sys_ack_unexpected", {63'd0, sys_ack}, 64'd0);
        end else begin
          check("sys_rdata", {32'd0, sys_rdata}, {32'd0, exp_sys_q.pop_front()});
        end
      end else begin
        check("sys_rdata_idle", {32'd0, sys_rdata}, 64'd0);
      end
      if (prev_ready === 1'b0 && mon_ready === 1'b1) begin
        if (exp_mon_q.size() == 0) begin
          check("mon_ready_unexpected", {63'd0, mon_ready}, 64'd0);
        end else begin
          check("mon_dreg", {32'd0, mon_dreg}, {32'd0, exp_mon_q.pop_front()});
        end
      end
      prev_ready = mon_ready;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // model bookkeeping for one accepted JTAG access at the model address
  task automatic model_jtag(input logic we, input logic [31:0] data);
    exp_mem_q.push_back({we, ja, data});
    exp_mon_q.push_back(we ? data : ref_mem[ja]);
    if (we) ref_mem[ja] = data;
    ja = ja + 8'd1;
  endtask

  task automatic model_sys(input logic we, input logic [7:0] addr, input logic [31:0] data);
    exp_mem_q.push_back({we, addr, data});
    exp_sys_q.push_back(we ? 32'd0 : ref_mem[addr]);
    if (we) ref_mem[addr] = data;
  endtask

  task automatic jtag_set(input logic [7:0] addr, input logic clr);
    step();
    jdo = '0;
    jdo[9:2] = addr;
    jdo[37] = clr;
    jtag_set_addr = 1'b1;
    ja = addr;
    step();
    jtag_set_addr = 1'b0;
    jdo = '0;
  endtask

  task automatic jtag_txn(input logic we, input logic [31:0] data, input logic also_set,
                          input logic [7:0] exp_addr, input logic [31:0] exp_dreg);
    step();
    jdo = '0;
    jdo[35] = we;
    jdo[34:3] = data;
    jtag_access = 1'b1;
    jtag_set_addr = also_set;
    model_jtag(we, data);
    step();
    jtag_access = 1'b0;
    jtag_set_addr = 1'b0;
    @(negedge clk);
    check("jtag_ready_n1", {63'd0, mon_ready}, 64'd0);
    @(negedge clk);
    check("jtag_mem_en_n2", {63'd0, mem_en}, 64'd1);
    check("jtag_addr_n2", {56'd0, mem_addr}, {56'd0, exp_addr});
    @(negedge clk);
    check("jtag_ready_n3", {63'd0, mon_ready}, 64'd0);
    @(negedge clk);
    check("jtag_ready_n4", {63'd0, mon_ready}, 64'd1);
    check("jtag_dreg_n4", {32'd0, mon_dreg}, {32'd0, exp_dreg});
  endtask

  task automatic sys_xfer(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata);
    step();
    sys_req = 1'b1;
    sys_we = we;
    sys_addr = addr;
    sys_wdata = wdata;
    model_sys(we, addr, wdata);
    step();
    @(negedge clk);
    check("sys_mem_en_n1", {63'd0, mem_en}, 64'd1);
    check("sys_addr_n1", {56'd0, mem_addr}, {56'd0, addr});
    step();
    @(negedge clk);
    check("sys_ack_n2", {63'd0, sys_ack}, 64'd1);
    check("sys_rdata_n2", {32'd0, sys_rdata}, {32'd0, exp_rdata});
    step();
    sys_req = 1'b0;
    @(negedge clk);
    check("sys_ack_n3", {63'd0, sys_ack}, 64'd0);
    @(negedge clk);
    check("sys_no_regrant_n4", {63'd0, mem_en}, 64'd0);
  endtask

  task automatic wait_ack(input string name);
    int k = 0;
    while (sys_ack !== 1'b1 && k < 16) begin
      @(negedge clk);
      k++;
    end
    check(name, {63'd0, sys_ack}, 64'd1);
    step();
    sys_req = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int k = 0;
    @(negedge clk);
    while (mon_ready !== 1'b1 && k < 16) begin
      @(negedge clk);
      k++;
    end
    check(name, {63'd0, mon_ready}, 64'd1);
  endtask

  // JTAG access in cycle n, system read of 0x20 joins in n+1 so both contend in IDLE
  task automatic tie_round(input int r, input logic [31:0] data);
    logic [7:0] jaddr_now;
    step();
    jdo = '0;
    jdo[35] = 1'b1;
    jdo[34:3] = data;
    jtag_access = 1'b1;
    jaddr_now = ja;
    if (tie_j[r]) begin
      model_jtag(1'b1, data);
      model_sys(1'b0, 8'h20, 32'd0);
    end else begin
      model_sys(1'b0, 8'h20, 32'd0);
      model_jtag(1'b1, data);
    end
    step();
    jtag_access = 1'b0;
    jdo = '0;
    sys_req = 1'b1;
    sys_we = 1'b0;
    sys_addr = 8'h20;
    @(negedge clk);
    @(negedge clk);
    check("tie_winner_addr", {56'd0, mem_addr}, {56'd0, (tie_j[r] ? jaddr_now : 8'h20)});
    wait_ack("tie_ack_seen");
    wait_ready("tie_ready");
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
`ifdef OCIMEM_ARB_ROUNDROBIN_EN
    tie_j = 3'b101;
`else
    tie_j = 3'b111;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h11] = 32'hA5A5_0011;
    mem[8'h20] = 32'h1234_5678;
    mem[8'h06] = 32'h0606_0606;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];

    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    started = 1'b1;
    check("rst_mem_en", {63'd0, mem_en}, 64'd0);
    check("rst_mem_addr", {56'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    check("rst_sys_ack", {63'd0, sys_ack}, 64'd0);
    check("rst_mon_dreg", {32'd0, mon_dreg}, 64'd0);
    check("rst_mon_ready", {63'd0, mon_ready}, 64'd1);
    check("rst_overrun", {63'd0, jtag_overrun}, 64'd0);

    // JTAG write then read with auto-increment
    jtag_set(8'h10, 1'b0);
    jtag_txn(1'b1, 32'hDEAD_BEEF, 1'b0, 8'h10, 32'hDEAD_BEEF);
    jtag_txn(1'b0, 32'd0, 1'b0, 8'h11, 32'hA5A5_0011);
    jtag_set(8'h10, 1'b0);
    jtag_txn(1'b0, 32'd0, 1'b0, 8'h10, 32'hDEAD_BEEF);

    // address wrap
    jtag_set(8'hFF, 1'b0);
    jtag_txn(1'b1, 32'h1111_1111, 1'b0, 8'hFF, 32'h1111_1111);
    jtag_txn(1'b1, 32'h2222_2222, 1'b0, 8'h00, 32'h2222_2222);

    // system master
    sys_xfer(1'b0, 8'h20, 32'd0, 32'h1234_5678);
    sys_xfer(1'b1, 8'h30, 32'hCAFE_F00D, 32'd0);
    sys_xfer(1'b0, 8'h30, 32'd0, 32'hCAFE_F00D);

    // contention: tie, solo JTAG, tie, solo system, tie
    tie_round(0, 32'h7000_0001);
    jtag_txn(1'b1, 32'h5A5A_0002, 1'b0, 8'h02, 32'h5A5A_0002);
    tie_round(1, 32'h7000_0003);
    sys_xfer(1'b0, 8'h20, 32'd0, 32'h1234_5678);
    tie_round(2, 32'h7000_0004);

    // dropped back-to-back strobe and sticky overrun
    step();
    jdo = '0;
    jdo[35] = 1'b1;
    jdo[34:3] = 32'h33;
    jtag_access = 1'b1;
    model_jtag(1'b1, 32'h33);
    step();
    jdo[34:3] = 32'h44;
    step();
    jtag_access = 1'b0;
    jdo = '0;
    @(negedge clk);
    check("overrun_set", {63'd0, jtag_overrun}, 64'd1);
    wait_ready("overrun_ready");
    check("overrun_sticky", {63'd0, jtag_overrun}, 64'd1);
    jtag_txn(1'b0, 32'd0, 1'b0, 8'h06, 32'h0606_0606);
    jtag_set(8'h40, 1'b0);
    @(negedge clk);
    check("overrun_kept_no_clr", {63'd0, jtag_overrun}, 64'd1);
    jtag_set(8'h40, 1'b1);
    @(negedge clk);
    check("overrun_cleared", {63'd0, jtag_overrun}, 64'd0);

    // simultaneous set_addr and access: access wins at current address
    jtag_txn(1'b1, 32'h77, 1'b1, 8'h40, 32'h77);
    check("overrun_simul", {63'd0, jtag_overrun}, 64'd1);
    jtag_set(8'h00, 1'b1);

    // reset during the ISSUE cycle of a system read
    step();
    sys_req = 1'b1;
    sys_we = 1'b0;
    sys_addr = 8'h20;
    exp_mem_q.push_back({1'b0, 8'h20, 32'd0});
    model_sys(1'b0, 8'h20, 32'd0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    ja = 8'h00;
    @(negedge clk);
    check("mid_rst_mem_en", {63'd0, mem_en}, 64'd0);
    check("mid_rst_mem_addr", {56'd0, mem_addr}, 64'd0);
    check("mid_rst_sys_ack", {63'd0, sys_ack}, 64'd0);
    check("mid_rst_mon_dreg", {32'd0, mon_dreg}, 64'd0);
    check("mid_rst_mon_ready", {63'd0, mon_ready}, 64'd1);
    wait_ack("rerequest_ack");
    jtag_txn(1'b0, 32'd0, 1'b0, 8'h00, 32'h2222_2222);

    repeat (3) step();
    check("ram_10", {32'd0, mem[8'h10]}, {32'd0, 32'hDEAD_BEEF});
    check("ram_ff", {32'd0, mem[8'hFF]}, {32'd0, 32'h1111_1111});
    check("ram_00", {32'd0, mem[8'h00]}, {32'd0, 32'h2222_2222});
    check("ram_30", {32'd0, mem[8'h30]}, {32'd0, 32'hCAFE_F00D});
    check("mem_q_drained", 64'(exp_mem_q.size()), 64'd0);
    check("sys_q_drained", 64'(exp_sys_q.size()), 64'd0);
    check("mon_q_drained", 64'(exp_mon_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
